// File: rtl/mr_latch_dac_pkg.sv
// Shared constants for the latched-code PWM / sigma-delta DAC: widths, mode
// encodings and pin bit positions.
package mr_latch_dac_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_SD  = 1'b1
    } mode_e;

    localparam int UIO_STROBE = 0;
    localparam int UIO_MODE   = 1;

    localparam int UO_DAC_BIT      = 0;
    localparam int UO_PERIOD_START = 1;
    localparam int UO_PENDING      = 2;
    localparam int UO_LOAD_ACK     = 3;

endpackage

// File: rtl/mr_latch_sync2.sv
// Two-flop synchronizer for one asynchronous level input.
module mr_latch_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_mr_latch_dac.sv
// 1-bit DAC: a requested code is latched on a strobe edge and applied at the next
// period wrap; output is PWM or first-order sigma-delta.
module tt_um_mr_latch_dac
    import mr_latch_dac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             strobe_sync, strobe_prev, load_event;
    logic             mode_sync;
    logic [WIDTH-1:0] in_code;
    mode_e            in_mode;

    logic [WIDTH-1:0] cnt, cnt_next, acc;
    logic [WIDTH-1:0] shadow_code, active_code, next_code;
    mode_e            shadow_mode, active_mode, next_mode;
    logic             pending, next_pending, load_ack, dac_bit, period_start;
    logic             wrap, acc_clear;
    logic [WIDTH:0]   sum;
    logic             unused_bits;

    mr_latch_sync2 u_sync_strobe (.clk(clk), .rst_n(rst_n), .d(uio_in[UIO_STROBE]), .q(strobe_sync));
    mr_latch_sync2 u_sync_mode   (.clk(clk), .rst_n(rst_n), .d(uio_in[UIO_MODE]),   .q(mode_sync));

    assign load_event  = strobe_sync & ~strobe_prev;
    assign in_code     = WIDTH'(ui_in);
    assign in_mode     = mode_e'(mode_sync);
    assign unused_bits = &{1'b0, uio_in[7:2]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_code    = active_code;
        next_mode    = active_mode;
        next_pending = pending;
        wrap         = ena && (cnt == '1);
        cnt_next     = cnt + WIDTH'(1);
        if (load_event && wrap) begin
            // Capture on the wrap edge bypasses the shadow straight into the new period.
            next_code    = in_code;
            next_mode    = in_mode;
            next_pending = 1'b0;
        end else if (wrap && pending) begin
            next_code    = shadow_code;
            next_mode    = shadow_mode;
            next_pending = 1'b0;
        end else if (load_event) begin
            next_pending = 1'b1;
        end
        acc_clear = wrap && ((next_code != active_code) || (next_mode != active_mode));
        sum       = {1'b0, (acc_clear ? '0 : acc)} + {1'b0, next_code};
    end

    // NOTE: every state flop, including the shadow and active code registers, is reset so a
    // pending code never survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev  <= 1'b0;
            load_ack     <= 1'b0;
            pending      <= 1'b0;
            shadow_code  <= '0;
            shadow_mode  <= MODE_PWM;
            active_code  <= '0;
            active_mode  <= MODE_PWM;
            cnt          <= '0;
            acc          <= '0;
            dac_bit      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            strobe_prev <= strobe_sync;
            load_ack    <= load_event;
            pending     <= next_pending;
            active_code <= next_code;
            active_mode <= next_mode;
            if (load_event) begin
                shadow_code <= in_code;
                shadow_mode <= in_mode;
            end
            // Outputs are computed from next-cycle values so dac_bit lines up with cnt.
            if (ena) begin
                cnt          <= cnt_next;
                acc          <= sum[WIDTH-1:0];
                period_start <= (cnt_next == '0);
                dac_bit      <= (next_mode == MODE_PWM) ? (cnt_next < next_code) : sum[WIDTH];
            end
        end
    end

    always_comb begin
        uo_out                  = '0;
        uo_out[UO_DAC_BIT]      = dac_bit;
        uo_out[UO_PERIOD_START] = period_start;
        uo_out[UO_PENDING]      = pending;
        uo_out[UO_LOAD_ACK]     = load_ack;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_mr_latch_dac.sv
// Directed bench for the latched-code DAC: latency, wrap-aligned updates,
// per-window ones counts and patterns, freeze and reset behaviour.
module tb_tt_um_mr_latch_dac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       strobe, mode;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int tests_run = 0;
    int tests_failed = 0;

    assign uio_in = {6'b0, mode, strobe};

    tt_um_mr_latch_dac dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       md;
        int         ones;
        int         first;
        int         maxrun;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe a code in; capture lands on the third edge after the strobe is raised.
    task automatic load(input logic [7:0] code, input logic md, input string name);
        ui_in  = code;
        mode   = md;
        strobe = 1'b1;
        repeat (3) tick();
        check({name, " load_ack"}, int'(uo_out[3]), 1);
        strobe = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_ps(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!uo_out[1] && n < 400);
        check({name, " period_start seen"}, int'(uo_out[1]), 1);
    endtask

    // Observe one full period starting at the cnt==0 sample.
    task automatic run_window(input logic [7:0] code, input logic md, input int exp_ones,
                              input int exp_first, input int exp_maxrun, input string name);
        int ones, first, maxrun, run, mism, ps;
        ones = 0; first = 256; maxrun = 0; run = 0; mism = 0; ps = 0;
        for (int k = 0; k < 256; k++) begin
            if (uo_out[0]) begin
                ones++;
                run++;
                if (first == 256) first = k;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (!md && (uo_out[0] != (k < int'(code)))) mism++;
            if (uo_out[1]) ps++;
            tick();
        end
        check({name, " ones"}, ones, exp_ones);
        check({name, " first_one"}, first, exp_first);
        check({name, " max_run"}, maxrun, exp_maxrun);
        check({name, " period_start_count"}, ps, 1);
        if (!md) check({name, " pwm_pattern_errors"}, mism, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt_a, cnt_b;

        vecs[0] = '{8'h55, 1'b1, 85, 3, 1};
        vecs[1] = '{8'hC0, 1'b1, 192, 1, 3};
        vecs[2] = '{8'hFF, 1'b0, 255, 0, 255};
        vecs[3] = '{8'h00, 1'b0, 0, 256, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 255, 1};
        vecs[5] = '{8'h40, 1'b0, 64, 0, 64};

        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; strobe = 1'b0; mode = 1'b0;
        repeat (3) tick();
        check("reset uo_out", int'(uo_out), 0);
        check("reset uio_out", int'(uio_out), 0);
        check("reset uio_oe", int'(uio_oe), 0);

        // First enabled edge takes cnt to 1, so cnt==0 returns after 256 edges.
        rst_n = 1'b1; ena = 1'b1;
        n = 0; cnt_a = 0;
        do begin
            tick();
            n++;
            cnt_a += int'(uo_out[0]);
        end while (!uo_out[1] && n < 400);
        check("first period length", n, 256);
        check("post-reset dac ones", cnt_a, 0);

        // Capture latency and single event for a held strobe.
        repeat (10) tick();
        ui_in = 8'h40; mode = 1'b0; strobe = 1'b1;
        tick(); check("latency ack edge N", int'(uo_out[3]), 0);
        tick(); check("latency ack edge N+1", int'(uo_out[3]), 0);
        tick(); check("latency ack edge N+2", int'(uo_out[3]), 1);
        check("latency pending", int'(uo_out[2]), 1);
        tick(); check("latency ack edge N+3", int'(uo_out[3]), 0);
        cnt_a = 0;
        repeat (8) begin tick(); cnt_a += int'(uo_out[3]); end
        check("held strobe extra acks", cnt_a, 0);
        strobe = 1'b0;
        n = 0; cnt_b = 0;
        while (!uo_out[1] && n < 400) begin
            cnt_b += int'(!uo_out[2]);
            tick();
            n++;
        end
        check("pending held until wrap", cnt_b, 0);
        check("pending cleared at wrap", int'(uo_out[2]), 0);
        run_window(8'h40, 1'b0, 64, 0, 64, "pwm40");

        for (int i = 0; i < 6; i++) begin
            repeat (10) tick();
            load(vecs[i].code, vecs[i].md, $sformatf("vec%0d", i));
            check($sformatf("vec%0d pending", i), int'(uo_out[2]), 1);
            wait_ps($sformatf("vec%0d", i), n);
            check($sformatf("vec%0d pending after wrap", i), int'(uo_out[2]), 0);
            run_window(vecs[i].code, vecs[i].md, vecs[i].ones, vecs[i].first,
                       vecs[i].maxrun, $sformatf("vec%0d", i));
        end

        // Two loads in one period: the later code wins.
        load(8'h10, 1'b0, "dbl first");
        load(8'hF0, 1'b0, "dbl second");
        wait_ps("dbl", n);
        run_window(8'hF0, 1'b0, 240, 0, 240, "dbl");

        // Capture coinciding with the wrap edge bypasses straight to active.
        repeat (253) tick();
        ui_in = 8'h80; mode = 1'b1; strobe = 1'b1;
        cnt_a = 0;
        repeat (3) begin tick(); cnt_a += int'(uo_out[2]); end
        strobe = 1'b0;
        check("bypass ack", int'(uo_out[3]), 1);
        check("bypass period_start", int'(uo_out[1]), 1);
        check("bypass pending seen", cnt_a, 0);
        run_window(8'h80, 1'b1, 128, 1, 1, "bypass");

        // Freeze mid-period; capture still works while frozen.
        load(8'hFF, 1'b0, "frz setup");
        wait_ps("frz setup", n);
        repeat (50) tick();
        check("frz dac before", int'(uo_out[0]), 1);
        ena = 1'b0;
        cnt_a = 0;
        repeat (20) begin tick(); cnt_a += int'(!uo_out[0]) + int'(uo_out[1]); end
        load(8'h20, 1'b0, "frz");
        repeat (74) begin tick(); cnt_a += int'(!uo_out[0]) + int'(uo_out[1]); end
        check("frz outputs changed", cnt_a, 0);
        check("frz pending", int'(uo_out[2]), 1);
        ena = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!uo_out[1] && n < 400);
        check("frz resume length", n, 206);
        run_window(8'h20, 1'b0, 32, 0, 32, "frz");

        // Reset mid-period with a pending code discards it.
        repeat (5) tick();
        load(8'h90, 1'b0, "rst");
        repeat (8'h7A - 11) tick();
        check("rst pending before", int'(uo_out[2]), 1);
        rst_n = 1'b0;
        #1;
        check("rst async uo_out", int'(uo_out), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (300) begin
            tick();
            cnt_a += int'(uo_out[0]);
            cnt_b += int'(uo_out[2]) + int'(uo_out[3]);
        end
        check("rst dac ones after", cnt_a, 0);
        check("rst pending/ack after", cnt_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
